// File: rtl/fx2_tx_arbiter_if.sv
// Byte path from the transmit arbiter to the FX2 bidir bridge.
// The arbiter is the master: it presents a byte and a valid flag,
// and the bridge answers with an accept strobe.
interface fx2_tx_arbiter_if;
  logic [7:0] FPGA_WORD;
  logic       FPGA_WORD_AVAILIABLE;
  logic       FPGA_WORD_ACCEPTED;

  modport master (
    output FPGA_WORD,
    output FPGA_WORD_AVAILIABLE,
    input  FPGA_WORD_ACCEPTED
  );

  modport slave (
    input  FPGA_WORD,
    input  FPGA_WORD_AVAILIABLE,
    output FPGA_WORD_ACCEPTED
  );
endinterface

// File: rtl/fx2_tx_arbiter.sv
// Round-robin transmit scheduler for the FPGA->PC byte path of the FX2 bridge.
// Every burst is one header byte {4'hA,2'b00,ch} followed by BURST_LEN data
// bytes. A source that stalls for TIMEOUT consecutive cycles mid-burst gets the
// rest of its burst filled with 8'h00 and the sticky PAD_ERR flag is raised.
// PC command bytes set the channel enables (8'h1m) and clear PAD_ERR (8'h20).
module fx2_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 FX2_CLK,
  input  logic                 RESET,
  input  logic [7:0]           PCINSTRUCTION,
  input  logic [8*NCH-1:0]     CH_DATA,
  input  logic [NCH-1:0]       CH_VALID,
  output logic [NCH-1:0]       CH_ACK,
  fx2_tx_arbiter_if.master     fx2,
  output logic [NCH-1:0]       CH_EN,
  output logic                 PAD_ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_PAD  = 2'd3
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);
  localparam logic [7:0] LAST_TMO = 8'(TIMEOUT - 1);
  localparam logic [1:0] LAST_CH  = 2'(NCH - 1);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [NCH-1:0]   ch_en_q, ch_en_d;
  logic             pad_err_q, pad_err_d;

  logic [NCH-1:0]   req_s;
  logic [NCH-1:0]   ack_s;
  logic [7:0]       sel_data_s;
  logic             sel_valid_s;
  logic [7:0]       word_s;
  logic             avail_s;
  logic             xfer_s;
  logic             pad_set_s;

  // First requesting channel after 'last', wrapping modulo NCH.
  function automatic logic [1:0] rr_pick(input logic [NCH-1:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      for (int j = 0; j < NCH; j++) begin
        if (!found && (j == ((int'(last) + k) % NCH)) && req[j]) begin
          pick  = 2'(j);
          found = 1'b1;
        end else begin
          pick  = pick;
          found = found;
        end
      end
    end
    return pick;
  endfunction

  assign req_s = CH_VALID & ch_en_q;

  // Mux out the byte and valid flag of the channel that owns the current burst.
  always_comb begin
    sel_data_s  = 8'h00;
    sel_valid_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q == 2'(i)) begin
        sel_data_s  = CH_DATA[8*i +: 8];
        sel_valid_s = CH_VALID[i];
      end else begin
        sel_data_s  = sel_data_s;
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Byte-path outputs per burst phase; silenced while RESET is held.
  always_comb begin
    word_s  = 8'h00;
    avail_s = 1'b0;
    if (RESET) begin
      word_s  = 8'h00;
      avail_s = 1'b0;
    end else begin
      case (state_q)
        S_HDR: begin
          avail_s = 1'b1;
          word_s  = {4'hA, 2'b00, grant_q};
        end
        S_DATA: begin
          avail_s = sel_valid_s;
          word_s  = sel_data_s;
        end
        S_PAD: begin
          avail_s = 1'b1;
          word_s  = 8'h00;
        end
        default: begin
          avail_s = 1'b0;
          word_s  = 8'h00;
        end
      endcase
    end
  end

  assign xfer_s = avail_s & fx2.FPGA_WORD_ACCEPTED;

  // Only the granted channel is acknowledged, and only for real data bytes.
  always_comb begin
    ack_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q == S_DATA) && (grant_q == 2'(i))) begin
        ack_s[i] = xfer_s;
      end else begin
        ack_s[i] = 1'b0;
      end
    end
  end

  // Burst sequencing: arbitration, header, data with stall timeout, padding.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    pad_set_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s != '0) begin
          grant_d      = rr_pick(req_s, last_grant_q);
          last_grant_d = rr_pick(req_s, last_grant_q);
          state_d      = S_HDR;
        end else begin
          state_d      = S_IDLE;
        end
      end
      S_HDR: begin
        if (xfer_s) begin
          state_d = S_DATA;
          cnt_d   = 8'd0;
          tmo_d   = 8'd0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          cnt_d = cnt_q + 8'd1;
          tmo_d = 8'd0;
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else if (!sel_valid_s) begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == LAST_TMO) begin
            state_d   = S_PAD;
            pad_set_s = 1'b1;
          end else begin
            state_d   = S_DATA;
          end
        end else begin
          // Source valid but bridge not accepting: not a stall.
          state_d = S_DATA;
        end
      end
      S_PAD: begin
        if (xfer_s) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAD;
          end
        end else begin
          state_d = S_PAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PC command decode; a new timeout beats a same-cycle clear of PAD_ERR.
  always_comb begin
    ch_en_d   = ch_en_q;
    pad_err_d = pad_err_q;
    if (PCINSTRUCTION[7:4] == 4'h1) begin
      ch_en_d = PCINSTRUCTION[NCH-1:0];
    end else begin
      ch_en_d = ch_en_q;
    end
    if (pad_set_s) begin
      pad_err_d = 1'b1;
    end else if (PCINSTRUCTION == 8'h20) begin
      pad_err_d = 1'b0;
    end else begin
      pad_err_d = pad_err_q;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge FX2_CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= LAST_CH;
      cnt_q        <= 8'd0;
      tmo_q        <= 8'd0;
      ch_en_q      <= '1;
      pad_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      ch_en_q      <= ch_en_d;
      pad_err_q    <= pad_err_d;
    end
  end

  assign fx2.FPGA_WORD            = word_s;
  assign fx2.FPGA_WORD_AVAILIABLE = avail_s;
  assign CH_ACK                   = ack_s;
  assign CH_EN                    = ch_en_q;
  assign PAD_ERR                  = pad_err_q;

endmodule
